// File: rtl/game_pkg.sv
// Shared game-flow definitions: phase encoding and field widths used by the
// sequencer, the VGA overlay and the seven-segment decode.
package game_pkg;

    localparam int LEVEL_W           = 4;
    localparam int LIVES_W           = 2;
    localparam int DEFAULT_MAX_LEVEL = 8;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_PLAY      = 3'd1,
        PH_DYING     = 3'd2,
        PH_LEVEL_UP  = 3'd3,
        PH_GAME_OVER = 3'd4,
        PH_VICTORY   = 3'd5
    } phase_e;

endpackage

// File: rtl/game_sequencer_if.sv
// Game-flow bundle between the sequencer and its consumers (frog, cars, VGA,
// collisions, seven-segment).
interface game_sequencer_if
    import game_pkg::*;
();

    logic               clk_enable;
    logic               start;
    logic               death_collision;
    logic               win_collision;
    logic [LEVEL_W-1:0] current_level;
    logic [LIVES_W-1:0] lives;
    logic               round_reset;
    logic               freeze;
    logic [2:0]         phase;
    logic               game_over;
    logic               victory;

    modport slave (
        input  clk_enable, start, death_collision, win_collision,
        output current_level, lives, round_reset, freeze, phase, game_over, victory
    );

    modport master (
        output clk_enable, start, death_collision, win_collision,
        input  current_level, lives, round_reset, freeze, phase, game_over, victory
    );

endinterface

// File: rtl/edge_detect.sv
// One-bit rising-edge detector: registers the previous input value and flags
// a 0->1 change for one clock.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic d_d;
    logic d_q;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_sequencer.sv
// Central frogger game-flow FSM: owns level, lives and phase, and drives the
// shared round-reset / freeze controls for the frog and car lanes.
module game_sequencer
    import game_pkg::*;
#(
    parameter int MAX_LEVEL    = DEFAULT_MAX_LEVEL,
    parameter int START_LIVES  = 3,
    parameter int DEATH_TICKS  = 50,
    parameter int BANNER_TICKS = 100,
    parameter int TIMER_W      = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    game_sequencer_if.slave bus
);

    if (DEATH_TICKS < 1 || BANNER_TICKS < 1) begin : g_bad_ticks
        $error("game_sequencer: DEATH_TICKS and BANNER_TICKS must be at least 1");
    end
    if (DEATH_TICKS > (1 << TIMER_W) || BANNER_TICKS > (1 << TIMER_W)) begin : g_bad_timer
        $error("game_sequencer: TIMER_W too narrow for the phase tick counts");
    end
    if (MAX_LEVEL < 1 || MAX_LEVEL >= (1 << LEVEL_W)) begin : g_bad_level
        $error("game_sequencer: MAX_LEVEL out of range");
    end
    if (START_LIVES < 1 || START_LIVES > 3) begin : g_bad_lives
        $error("game_sequencer: START_LIVES must be 1..3");
    end

    localparam logic [TIMER_W-1:0] DEATH_LAST  = TIMER_W'(DEATH_TICKS - 1);
    localparam logic [TIMER_W-1:0] BANNER_LAST = TIMER_W'(BANNER_TICKS - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX   = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE   = LEVEL_W'(1);
    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(START_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

    phase_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               round_reset_q, round_reset_d;
    logic               freeze_q, freeze_d;
    logic               game_over_q, game_over_d;
    logic               victory_q, victory_d;

    logic start_rise;
    logic death_rise;
    logic win_rise;

    edge_detect u_start_edge (.clk(clk), .reset_n(reset_n), .d(bus.start),           .rise(start_rise));
    edge_detect u_death_edge (.clk(clk), .reset_n(reset_n), .d(bus.death_collision), .rise(death_rise));
    edge_detect u_win_edge   (.clk(clk), .reset_n(reset_n), .d(bus.win_collision),   .rise(win_rise));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PH_IDLE;
            level_q       <= LEVEL_ONE;
            lives_q       <= LIVES_INIT;
            timer_q       <= '0;
            round_reset_q <= 1'b0;
            freeze_q      <= 1'b1;
            game_over_q   <= 1'b0;
            victory_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            timer_q       <= timer_d;
            round_reset_q <= round_reset_d;
            freeze_q      <= freeze_d;
            game_over_q   <= game_over_d;
            victory_q     <= victory_d;
        end
    end

    // Collision edges only matter in PLAY; a death outranks a simultaneous win.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        lives_d = lives_q;
        timer_d = timer_q;
        case (state_q)
            PH_IDLE: begin
                if (start_rise) begin
                    state_d = PH_PLAY;
                    level_d = LEVEL_ONE;
                    lives_d = LIVES_INIT;
                end
            end
            PH_PLAY: begin
                if (death_rise) begin
                    timer_d = '0;
                    if (lives_q > LIVES_ONE) begin
                        state_d = PH_DYING;
                        lives_d = lives_q - LIVES_ONE;
                    end else begin
                        state_d = PH_GAME_OVER;
                        lives_d = '0;
                    end
                end else if (win_rise) begin
                    if (level_q < LEVEL_MAX) begin
                        state_d = PH_LEVEL_UP;
                        level_d = level_q + LEVEL_ONE;
                        timer_d = '0;
                    end else begin
                        state_d = PH_VICTORY;
                    end
                end
            end
            PH_DYING: begin
                if (bus.clk_enable) begin
                    if (timer_q == DEATH_LAST) begin
                        state_d = PH_PLAY;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
            end
            PH_LEVEL_UP: begin
                if (bus.clk_enable) begin
                    if (timer_q == BANNER_LAST) begin
                        state_d = PH_PLAY;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
            end
            PH_GAME_OVER, PH_VICTORY: begin
                if (start_rise) begin
                    state_d = PH_IDLE;
                end
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase
    end

    // Status flags are derived from the next state so they land with it.
    always_comb begin
        round_reset_d = (state_d == PH_PLAY) && (state_q != PH_PLAY);
        freeze_d      = (state_d != PH_PLAY);
        game_over_d   = (state_d == PH_GAME_OVER);
        victory_d     = (state_d == PH_VICTORY);
    end

    assign bus.current_level = level_q;
    assign bus.lives         = lives_q;
    assign bus.round_reset   = round_reset_q;
    assign bus.freeze        = freeze_q;
    assign bus.phase         = state_q;
    assign bus.game_over     = game_over_q;
    assign bus.victory       = victory_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a game-rules model queues the expected
// phase changes and a monitor checks each change the DUT presents.
module tb_game_sequencer;

    localparam int MAXL   = 8;
    localparam int SLIVES = 3;
    localparam int DT     = 50;
    localparam int BT     = 100;

    typedef struct {
        int phase;
        int level;
        int lives;
        int ticks;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    game_sequencer_if bus();

    game_sequencer #(
        .MAX_LEVEL(MAXL), .START_LIVES(SLIVES), .DEATH_TICKS(DT),
        .BANNER_TICKS(BT), .TIMER_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   m_phase = 0;
    int   m_level = 1;
    int   m_lives = SLIVES;
    int   mon_ticks = 0;
    int   last_phase = 0;
    bit   prev_en = 1'b0;
    bit   just_changed = 1'b0;
    int   r;
    int   n;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void push(int p, int l, int v, int t);
        exp_t x;
        x.phase = p;
        x.level = l;
        x.lives = v;
        x.ticks = t;
        exp_q.push_back(x);
    endfunction

    initial begin
        bus.clk_enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.clk_enable = ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: every phase change pops one expected record.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_en) mon_ticks++;
            if (just_changed) begin
                chk("round_reset_width", int'(bus.round_reset), 0);
                just_changed = 1'b0;
            end
            if (int'(bus.phase) != last_phase) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_phase", int'(bus.phase), last_phase);
                end else begin
                    e = exp_q.pop_front();
                    chk("phase", int'(bus.phase), e.phase);
                    if (e.level >= 0) chk("level", int'(bus.current_level), e.level);
                    if (e.lives >= 0) chk("lives", int'(bus.lives), e.lives);
                    if (e.ticks >= 0) chk("phase_ticks", mon_ticks, e.ticks);
                    chk("freeze", int'(bus.freeze), int'(e.phase != 1));
                    chk("game_over", int'(bus.game_over), int'(e.phase == 4));
                    chk("victory", int'(bus.victory), int'(e.phase == 5));
                    chk("round_reset", int'(bus.round_reset), int'(e.phase == 1));
                end
                last_phase = int'(bus.phase);
                mon_ticks = 0;
                just_changed = 1'b1;
            end
            prev_en = bus.clk_enable;
        end
    end

    task automatic hit(int kind, int hold);
        @(posedge clk);
        #1;
        bus.start           = (kind == 0);
        bus.death_collision = (kind == 1 || kind == 3);
        bus.win_collision   = (kind == 2 || kind == 3);
        repeat (hold) @(posedge clk);
        #1;
        bus.start           = 1'b0;
        bus.death_collision = 1'b0;
        bus.win_collision   = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 4000) begin
            @(posedge clk);
            k++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic do_start();
        if (m_phase == 0) begin
            m_phase = 1;
            m_level = 1;
            m_lives = SLIVES;
            push(1, 1, SLIVES, -1);
        end else if (m_phase == 4 || m_phase == 5) begin
            m_phase = 0;
            push(0, -1, -1, -1);
        end
        hit(0, $urandom_range(1, 4));
        wait_idle("start");
    endtask

    task automatic do_death(int hold, bit with_win);
        if (m_phase == 1) begin
            if (m_lives > 1) begin
                m_lives--;
                push(2, m_level, m_lives, -1);
                push(1, m_level, m_lives, DT);
            end else begin
                m_lives = 0;
                m_phase = 4;
                push(4, m_level, 0, -1);
            end
        end
        hit(with_win ? 3 : 1, hold);
        wait_idle("death");
    endtask

    task automatic do_win(int hold);
        if (m_phase == 1) begin
            if (m_level < MAXL) begin
                m_level++;
                push(3, m_level, m_lives, -1);
                push(1, m_level, m_lives, BT);
            end else begin
                m_phase = 5;
                push(5, m_level, m_lives, -1);
            end
        end
        hit(2, hold);
        wait_idle("win");
    endtask

    initial begin
        bus.start = 1'b0;
        bus.death_collision = 1'b0;
        bus.win_collision = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_phase", int'(bus.phase), 0);
        chk("rst_level", int'(bus.current_level), 1);
        chk("rst_lives", int'(bus.lives), SLIVES);
        chk("rst_freeze", int'(bus.freeze), 1);
        chk("rst_round_reset", int'(bus.round_reset), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        chk("rst_victory", int'(bus.victory), 0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        do_start();
        do_death(20, 1'b0);
        do_death($urandom_range(1, 5), 1'b0);
        do_death($urandom_range(1, 5), 1'b0);
        chk("go_lives_zero", int'(bus.lives), 0);
        do_start();
        do_start();
        for (int i = 0; i < MAXL; i++) do_win($urandom_range(1, 6));
        chk("victory_level", int'(bus.current_level), MAXL);
        do_start();
        do_start();
        do_win(2);
        do_win(2);
        do_death(3, 1'b1);
        chk("both_level", int'(bus.current_level), 3);

        // Death from PLAY, then async reset roughly halfway through DYING.
        m_lives--;
        push(2, m_level, m_lives, -1);
        hit(1, 2);
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        n = 0;
        while (mon_ticks < 25 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("mid_dying_reached", int'(mon_ticks >= 25), 1);
        exp_q.delete();
        push(0, 1, SLIVES, -1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_phase", int'(bus.phase), 0);
        chk("mid_rst_freeze", int'(bus.freeze), 1);
        chk("mid_rst_round_reset", int'(bus.round_reset), 0);
        chk("mid_rst_lives", int'(bus.lives), SLIVES);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        m_phase = 0;
        m_level = 1;
        m_lives = SLIVES;
        wait_idle("mid_rst");
        do_start();
        do_death($urandom_range(1, 20), 1'b0);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) do_start();
            else if (r < 5) do_death($urandom_range(1, 20), ($urandom_range(0, 3) == 0));
            else do_win($urandom_range(1, 20));
        end
        wait_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Central game-flow FSM for frogger. It owns level, lives and phase state, and replaces the ad-hoc level register in the top module. It consumes the collision flags and sequences the frog and car lanes through play, death freeze, level-up banner, game-over and final-win phases. It drives the shared round-reset and freeze controls for the frog and car instances, and the level/lives values consumed by the VGA, collisions and seven-segment logic.

Parameters:
MAX_LEVEL, 8, highest level; a win at this level enters VICTORY
START_LIVES, 3, lives loaded at game start (1..3)
DEATH_TICKS, 50, clk_enable ticks spent in DYING
BANNER_TICKS, 100, clk_enable ticks spent in LEVEL_UP
TIMER_W, 8, width of the phase timer; must hold max(DEATH_TICKS, BANNER_TICKS)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clk_enable  in  1  one-cycle tick from ClockDivider; paces phase timers
start  in  1  start/continue button (switch1), already synchronised, level-sensitive
death_collision  in  1  frog hit a car or hazard (level, may stay high several cycles)
win_collision  in  1  frog reached goal row (level)
current_level  out  4  active level, 1..MAX_LEVEL
lives  out  2  remaining lives
round_reset  out  1  one-clk pulse; returns frog and cars to start positions
freeze  out  1  high when car and frog motion must be held
phase  out  3  encoded state, for VGA overlays
game_over  out  1  high in GAME_OVER
victory  out  1  high in VICTORY

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, current_level=1, lives=START_LIVES, timer=0, round_reset=0, freeze=1, game_over=0, victory=0, start_q=0.
- Edge detection and sampling:
  - start is rising-edge detected with a registered start_q.
  - death_collision and win_collision are sampled only in PLAY and are rising-edge detected, so one hit produces one event.
- State encodings:
  - IDLE=0, PLAY=1, DYING=2, LEVEL_UP=3, GAME_OVER=4, VICTORY=5.
  - Unused codes 6 and 7 go to IDLE.
- Transitions:
  - IDLE: on start rise, go to PLAY with round_reset pulsed, current_level=1, lives=START_LIVES.
  - PLAY, death event with lives>1: go to DYING, lives-1, timer=0.
  - PLAY, death event with lives==1: go to GAME_OVER, lives=0.
  - PLAY, win event with current_level<MAX_LEVEL: go to LEVEL_UP, current_level+1, timer=0.
  - PLAY, win event with current_level==MAX_LEVEL: go to VICTORY.
  - Death and win events in the same cycle: death wins.
  - DYING: the timer increments on clk_enable. When timer==DEATH_TICKS-1 and clk_enable=1, go to PLAY with round_reset pulsed. The level is unchanged.
  - LEVEL_UP: same mechanism with BANNER_TICKS. On exit, go to PLAY with round_reset pulsed.
  - GAME_OVER / VICTORY: hold until a start rise, then go to IDLE. The next start rise begins a new game.
- round_reset:
  - Registered, high for exactly the one clk in which the state first equals PLAY.
  - Never asserted in any other state.
- freeze:
  - freeze = (state != PLAY). It is registered alongside state, so zero relative latency.
- Outputs:
  - game_over = (state==GAME_OVER); victory = (state==VICTORY). Both registered.
- Arithmetic:
  - current_level saturates at MAX_LEVEL and never wraps to 0.
  - lives never underflows.
  - The timer compare uses TIMER_W bits; DEATH_TICKS/BANNER_TICKS of 0 are illegal (elaboration check).
- Timer timing:
  - Entering DYING/LEVEL_UP on a cycle with clk_enable=1 does not count that tick; counting starts the next tick.
- Reset mid-operation:
  - Asynchronous return to reset values from any state, including mid-timer. No round_reset pulse is produced by the reset itself.

Decomposition:
- Shared package game_pkg:
  - state encoding constants (PH_IDLE..PH_VICTORY)
  - LEVEL_W=4, LIVES_W=2
  - default MAX_LEVEL
  - These are also used by the VGA overlay and the seven-segment decode.
- One sub-module, edge_detect: a 1-bit registered rising-edge detector with async active-low reset. It is instantiated three times (start, death, win).

Test Plan:
- Reset then start rise: one clk later phase=1, round_reset high exactly 1 clk, freeze=0, current_level=1, lives=3.
- In PLAY, death_collision held high 20 clks: one event only. phase=2, lives=2, freeze=1. After 50 clk_enable ticks, phase=1 with one round_reset pulse and current_level still 1.
- Three deaths from start: third gives phase=4, game_over=1, lives=0. Start rise gives phase=0; a second start rise restarts with lives=3, level=1.
- win_collision at levels 1..7: each gives LEVEL_UP (phase=3) for 100 ticks then PLAY, current_level 2..8. A win at level 8 gives phase=5, victory=1, level stays 8.
- death_collision and win_collision rising in the same clk at level 3: phase=2, lives decremented, level stays 3.
- reset_n asserted mid-DYING at tick 25: outputs immediately return to reset values (phase=0, freeze=1, round_reset=0). After release, the timer restarts from 0 on the next death.
